spi_cmd_slave: RTL and testbench
================================

# spi_cmd_slave

Parametrised SPI command slave: a byte-oriented SPI target on an oversampling system clock that decodes a one-byte opcode and then runs echo, RAM write/read with auto-increment, GPIO direction/data or info transactions. It is the generalised successor of the fixed 4-GPIO, fixed-mode command slave. It adds configurable SPI mode, GPIO width and RAM depth, deterministic read data, address wrap and an error state. It sits at board top level between the external SPI master pins and on-chip RAM/GPIO.

## Interface
- GPIO_W, 4, GPIO pin count, 1..8
- RAM_AW, 4, RAM address width; depth 2**RAM_AW, 1..8
- CPOL, 1, idle level of mclk
- CPHA, 1, 0 = sample on first edge, 1 = sample on second edge
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- mselect  in  1  SPI chip select, active-low, asynchronous to clk
- mclk  in  1  SPI bit clock, asynchronous to clk
- mosi  in  1  master data out
- miso  out  1  slave data out, MSB first; reset 0, 0 while deselected
- gpio  inout  GPIO_W  per-bit tristate: driven from gpio_out when gpio_dir bit = 1, else Z; reset all Z
- err  out  1  high from a bad opcode until deselect; reset 0

## Operation
- mselect, mclk, mosi pass through 2-flop synchronisers. Sample and shift edges are derived from CPOL/CPHA.
- A byte completes on its 8th sample edge. The response for byte n is loaded into the TX shifter when byte n-1 completes. When mselect falls, the TX shifter loads 0x00.
- Byte 0 is the opcode; its response is 0x00. Byte 1 response is ACK = opcode + 0x11 for valid opcodes, or 0xEE if invalid.
- 0x11 ECHO: the response to byte n≥2 is byte n-1.
- 0x12 WRITE: byte 1 loads addr (low RAM_AW bits). Each byte n≥2 writes ram[addr] and then increments addr, wrapping modulo depth.
- 0x13 READ: byte 1 loads addr. The response to byte n≥2 is ram[addr], then addr increments (wraps). MOSI data is ignored.
- 0x14 GPIO_DIR: every byte n≥1 sets gpio_dir = byte[GPIO_W-1:0]; the last byte wins.
- 0x15 GPIO_DATA: every byte n≥1 sets gpio_out = byte[GPIO_W-1:0]. The response to byte n≥2 is the synchronised gpio pins sampled at completion of byte n-1, zero-extended to 8 bits.
- 0x16 INFO: byte 2 returns GPIO_W, byte 3 returns RAM_AW, later bytes return 0x00.
- Any other opcode: err=1, state S_ERR; responses are 0xEE and no side effects occur until deselect.
- State sequence:
  - S_IDLE goes to S_START or S_ERR when the opcode completes.
  - On byte 1 completion, S_START goes to S_ECHO, S_WRITE_ADDR, S_READ_ADDR, S_GPIO_DIR, S_GPIO_DATA or S_INFO.
  - On byte 2 completion, S_WRITE_ADDR goes to S_WRITE_DATA and S_READ_ADDR goes to S_READ_DATA.
  - All other states hold.
- Deselect (synchronised mselect high) in any state does all of the following:
  - returns to S_IDLE;
  - discards any partial byte, with no RAM or GPIO side effect;
  - clears err;
  - drives miso to 0.
- RAM and GPIO registers persist across transactions.

## Timing
- mclk half-period must be ≥ 4 clk periods. mselect setup to the first mclk edge and hold after the last edge must be ≥ 4 clk.
- Deselect-to-S_IDLE latency: ≤ 3 clk after the mselect pin rises.
- A RAM write or GPIO register update occurs ≤ 2 clk after the byte-completing sample edge is synchronised.
- The next miso bit is valid ≤ 3 clk after the shift edge at the pin. For CPHA=0, the MSB is valid before the first sample edge.
- Reset values: state S_IDLE, gpio_dir 0, gpio_out 0, addr 0, err 0, miso 0. RAM is not reset.
- rst_n asserted mid-transaction aborts immediately. After release, the slave waits for mselect high before accepting an opcode.

## Structure
- Package spi_cmd_pkg holds:
  - the opcode constants (OP_ECHO 0x11 … OP_INFO 0x16);
  - ACK_OFFSET 0x11 and ERR_BYTE 0xEE;
  - the state enum.
- Sub-module spi_byte_slave(CPOL, CPHA) contains the synchronisers, edge detection and RX/TX shifters. It outputs a byte_done pulse with rx_byte, a tx_load strobe with tx_byte, and a selected flag.
- The top level contains the FSM, addr counter, RAM array and GPIO registers.

## Test plan
- CPOL=1, CPHA=1: send 0x11, 0x42, 0x43, 0x44 -> responses 0x00, 0x22, 0x42, 0x43; state goes S_START then S_ECHO; deselect gives S_IDLE within 3 clk.
- Send 0x12, 0x04, 0xAB, 0xCD, then deselect mid-way through 0xEF -> ram[4]=0xAB, ram[5]=0xCD, ram[6] unchanged.
- Send 0x13, 0x03, then four dummy bytes -> responses 0x00, 0x24, ram[3], 0xAB, 0xCD, ram[6].
- With RAM_AW=4: WRITE at addr 0x0F with 0x11, 0x22 -> ram[15]=0x11, ram[0]=0x22.
- With GPIO_W=4 and pin 0 driven by the bench:
  - 0x15, 0x00, then 0x00 twice while the bench toggles pin 0 from 0 to 1 -> responses 0x26, then 0x00, then 0x01 on the low bit;
  - 0x14, 0x01 followed by 0x15, 0x01 -> gpio = zzz1.
- Invalid opcode 0x99 -> err=1 and response 0xEE. On deselect, err=0, and a following 0x16, 0x00, 0x00, 0x00 returns 0x27, 0x04, 0x04. Repeat the echo scenario for all four CPOL/CPHA combinations.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared constants, FSM state type and opcode helper for the SPI command slave.
package spi_cmd_pkg;

  localparam logic [7:0] OP_ECHO      = 8'h11;
  localparam logic [7:0] OP_WRITE     = 8'h12;
  localparam logic [7:0] OP_READ      = 8'h13;
  localparam logic [7:0] OP_GPIO_DIR  = 8'h14;
  localparam logic [7:0] OP_GPIO_DATA = 8'h15;
  localparam logic [7:0] OP_INFO      = 8'h16;

  localparam logic [7:0] ACK_OFFSET   = 8'h11;
  localparam logic [7:0] ERR_BYTE     = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ECHO,
    S_WRITE_ADDR,
    S_WRITE_DATA,
    S_READ_ADDR,
    S_READ_DATA,
    S_GPIO_DIR,
    S_GPIO_DATA,
    S_INFO,
    S_ERR
  } state_e;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op >= OP_ECHO) && (op <= OP_INFO);
  endfunction

endpackage

// File: rtl/spi_byte_slave.sv
// Byte-level SPI target: input synchronisers, mode-dependent edge detection,
// RX/TX shift registers. Emits one byte_done pulse per completed byte.
module spi_byte_slave #(
  parameter int unsigned CPOL = 1,
  parameter int unsigned CPHA = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mselect,
  input  logic       i_mclk,
  input  logic       i_mosi,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_byte,
  output logic       o_miso,
  output logic       o_selected,
  output logic       o_byte_done,
  output logic [7:0] o_rx_byte
);

  localparam logic       L_IDLE_LVL = (CPOL != 0);
  // Shift edge on which the staged response byte enters the shifter: the first
  // leading edge of a byte (CPHA=1) or the trailing edge after the 8th sample (CPHA=0).
  localparam logic [2:0] L_LOAD_CNT = (CPHA != 0) ? 3'd0 : 3'd7;

  logic [1:0] r_cs_sync;
  logic [1:0] r_sck_sync;
  logic       r_sck_prev;
  logic [1:0] r_mosi_sync;
  logic       r_armed;
  logic [6:0] r_rx_sr;
  logic [2:0] r_rx_cnt;
  logic       r_byte_done;
  logic [7:0] r_rx_byte;
  logic [7:0] r_tx_sr;
  logic [7:0] r_tx_hold;
  logic [2:0] r_tx_cnt;

  logic w_sel;
  logic w_rise;
  logic w_fall;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;

  // Synchronisers; cs resets to "selected" so arming needs a real deselect after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_sync   <= 2'b00;
      r_sck_sync  <= {2{L_IDLE_LVL}};
      r_sck_prev  <= L_IDLE_LVL;
      r_mosi_sync <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], i_mselect};
      r_sck_sync  <= {r_sck_sync[0], i_mclk};
      r_sck_prev  <= r_sck_sync[1];
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_armed     <= r_armed | r_cs_sync[1];
    end
  end

  assign w_sel    = r_armed & ~r_cs_sync[1];
  assign w_rise   = r_sck_sync[1] & ~r_sck_prev;
  assign w_fall   = ~r_sck_sync[1] & r_sck_prev;
  assign w_lead   = (CPOL != 0) ? w_fall : w_rise;
  assign w_trail  = (CPOL != 0) ? w_rise : w_fall;
  assign w_sample = w_sel & ((CPHA != 0) ? w_trail : w_lead);
  assign w_shift  = w_sel & ((CPHA != 0) ? w_lead : w_trail);

  // Receive shifter; a partial byte is dropped whenever the target is deselected
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_sr     <= 7'd0;
      r_rx_cnt    <= 3'd0;
      r_byte_done <= 1'b0;
      r_rx_byte   <= 8'h00;
    end else begin
      r_byte_done <= 1'b0;
      if (!w_sel) begin
        r_rx_cnt <= 3'd0;
      end else if (w_sample) begin
        r_rx_sr  <= {r_rx_sr[5:0], r_mosi_sync[1]};
        r_rx_cnt <= r_rx_cnt + 3'd1;
        if (r_rx_cnt == 3'd7) begin
          r_byte_done <= 1'b1;
          r_rx_byte   <= {r_rx_sr, r_mosi_sync[1]};
        end
      end
    end
  end

  // Transmit shifter with a one-byte staging register fed by tx_load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_sr   <= 8'h00;
      r_tx_hold <= 8'h00;
      r_tx_cnt  <= 3'd0;
    end else if (!w_sel) begin
      r_tx_sr   <= 8'h00;
      r_tx_hold <= 8'h00;
      r_tx_cnt  <= 3'd0;
    end else begin
      if (i_tx_load) begin
        r_tx_hold <= i_tx_byte;
      end
      if (w_shift) begin
        r_tx_sr  <= (r_tx_cnt == L_LOAD_CNT) ? r_tx_hold : {r_tx_sr[6:0], 1'b0};
        r_tx_cnt <= r_tx_cnt + 3'd1;
      end
    end
  end

  assign o_miso      = w_sel & r_tx_sr[7];
  assign o_selected  = w_sel;
  assign o_byte_done = r_byte_done;
  assign o_rx_byte   = r_rx_byte;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI command slave: opcode FSM, auto-incrementing RAM port, GPIO registers.
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int unsigned GPIO_W = 4,
  parameter int unsigned RAM_AW = 4,
  parameter int unsigned CPOL   = 1,
  parameter int unsigned CPHA   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mselect,
  input  logic              i_mclk,
  input  logic              i_mosi,
  output logic              o_miso,
  inout  wire  [GPIO_W-1:0] io_gpio,
  output logic              o_err
);

  state_e              r_state;
  state_e              w_state_d;
  logic [7:0]          r_opcode;
  logic [1:0]          r_byte_cnt;
  logic [RAM_AW-1:0]   r_addr;
  logic [RAM_AW-1:0]   w_addr_d;
  logic [GPIO_W-1:0]   r_gpio_dir;
  logic [GPIO_W-1:0]   r_gpio_out;
  logic [GPIO_W-1:0]   r_gpio_sync0;
  logic [GPIO_W-1:0]   r_gpio_sync1;
  logic                r_err;
  logic [7:0]          r_ram [2**RAM_AW];

  logic                w_sel;
  logic                w_byte_done;
  logic [7:0]          w_rx_byte;
  logic [7:0]          w_tx_byte;
  logic [RAM_AW-1:0]   w_rx_addr;
  logic [7:0]          w_pins8;
  logic                w_op_load;
  logic                w_ram_we;
  logic                w_dir_we;
  logic                w_out_we;
  logic                w_err_set;

  spi_byte_slave #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_byte (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_mselect   (i_mselect),
    .i_mclk      (i_mclk),
    .i_mosi      (i_mosi),
    .i_tx_load   (w_byte_done),
    .i_tx_byte   (w_tx_byte),
    .o_miso      (o_miso),
    .o_selected  (w_sel),
    .o_byte_done (w_byte_done),
    .o_rx_byte   (w_rx_byte)
  );

  assign w_rx_addr = w_rx_byte[RAM_AW-1:0];
  assign w_pins8   = 8'(r_gpio_sync1);

  // Next state, side-effect strobes and the response for the byte after this one
  always_comb begin
    w_state_d = r_state;
    w_tx_byte = 8'h00;
    w_addr_d  = r_addr;
    w_op_load = 1'b0;
    w_ram_we  = 1'b0;
    w_dir_we  = 1'b0;
    w_out_we  = 1'b0;
    w_err_set = 1'b0;
    if (w_byte_done && w_sel) begin
      unique case (r_state)
        S_IDLE: begin
          w_op_load = 1'b1;
          if (is_valid_op(w_rx_byte)) begin
            w_state_d = S_START;
            w_tx_byte = w_rx_byte + ACK_OFFSET;
          end else begin
            w_state_d = S_ERR;
            w_tx_byte = ERR_BYTE;
            w_err_set = 1'b1;
          end
        end
        S_START: begin
          case (r_opcode)
            OP_ECHO: begin
              w_state_d = S_ECHO;
              w_tx_byte = w_rx_byte;
            end
            OP_WRITE: begin
              w_state_d = S_WRITE_ADDR;
              w_addr_d  = w_rx_addr;
            end
            OP_READ: begin
              // First read byte is served straight from the address just received
              w_state_d = S_READ_ADDR;
              w_tx_byte = r_ram[w_rx_addr];
              w_addr_d  = w_rx_addr + RAM_AW'(1);
            end
            OP_GPIO_DIR: begin
              w_state_d = S_GPIO_DIR;
              w_dir_we  = 1'b1;
            end
            OP_GPIO_DATA: begin
              w_state_d = S_GPIO_DATA;
              w_out_we  = 1'b1;
              w_tx_byte = w_pins8;
            end
            default: begin
              w_state_d = S_INFO;
              w_tx_byte = 8'(GPIO_W);
            end
          endcase
        end
        S_ECHO: w_tx_byte = w_rx_byte;
        S_WRITE_ADDR, S_WRITE_DATA: begin
          w_state_d = S_WRITE_DATA;
          w_ram_we  = 1'b1;
          w_addr_d  = r_addr + RAM_AW'(1);
        end
        S_READ_ADDR, S_READ_DATA: begin
          w_state_d = S_READ_DATA;
          w_tx_byte = r_ram[r_addr];
          w_addr_d  = r_addr + RAM_AW'(1);
        end
        S_GPIO_DIR: w_dir_we = 1'b1;
        S_GPIO_DATA: begin
          w_out_we  = 1'b1;
          w_tx_byte = w_pins8;
        end
        S_INFO: w_tx_byte = (r_byte_cnt == 2'd2) ? 8'(RAM_AW) : 8'h00;
        S_ERR: w_tx_byte = ERR_BYTE;
      endcase
    end
    if (!w_sel) begin
      w_state_d = S_IDLE;
    end
  end

  // FSM state, opcode, byte index, address and GPIO control registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_opcode   <= 8'h00;
      r_byte_cnt <= 2'd0;
      r_addr     <= '0;
      r_gpio_dir <= '0;
      r_gpio_out <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      if (w_op_load) begin
        r_opcode <= w_rx_byte;
      end
      if (!w_sel) begin
        r_byte_cnt <= 2'd0;
        r_err      <= 1'b0;
      end else begin
        if (w_byte_done && (r_byte_cnt != 2'd3)) begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
      if (w_dir_we) begin
        r_gpio_dir <= w_rx_byte[GPIO_W-1:0];
      end
      if (w_out_we) begin
        r_gpio_out <= w_rx_byte[GPIO_W-1:0];
      end
    end
  end

  // Pin synchroniser for GPIO readback
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpio_sync0 <= '0;
      r_gpio_sync1 <= '0;
    end else begin
      r_gpio_sync0 <= io_gpio;
      r_gpio_sync1 <= r_gpio_sync0;
    end
  end

  // Data RAM, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_ram[r_addr] <= w_rx_byte;
    end
  end

  for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_gpio
    assign io_gpio[gi] = r_gpio_dir[gi] ? r_gpio_out[gi] : 1'bz;
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench: one DUT per SPI mode; instance 3 (CPOL=1, CPHA=1) runs the full plan.
module tb_spi_cmd_slave;
  import spi_cmd_pkg::*;

  localparam int HALF  = 6;
  localparam int SETUP = 6;

  logic       r_clk = 1'b0;
  logic       r_rst_n;
  logic [3:0] r_msel;
  logic [3:0] r_mclk;
  logic       r_mosi;
  logic       r_pin;
  logic       r_pin_en;
  wire  [3:0] w_miso;
  wire  [3:0] w_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 r_clk = ~r_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wire [3:0] w_gpio;
    if (g == 3) begin : g_drv
      assign w_gpio[0] = r_pin_en ? r_pin : 1'bz;
    end
    spi_cmd_slave #(
      .GPIO_W (4),
      .RAM_AW (4),
      .CPOL   (g / 2),
      .CPHA   (g % 2)
    ) u_dut (
      .i_clk     (r_clk),
      .i_rst_n   (r_rst_n),
      .i_mselect (r_msel[g]),
      .i_mclk    (r_mclk[g]),
      .i_mosi    (r_mosi),
      .o_miso    (w_miso[g]),
      .io_gpio   (w_gpio),
      .o_err     (w_err[g])
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic spi_select(input int m);
    wait_clk(4);
    r_msel[m] = 1'b0;
    wait_clk(SETUP);
  endtask

  // Deselect and return 3 clk after the pin rises
  task automatic spi_deselect(input int m);
    wait_clk(SETUP);
    r_msel[m] = 1'b1;
    repeat (3) @(posedge r_clk);
    #1;
  endtask

  // Master side of n bits, MSB first; rx collects miso at each sample edge
  task automatic spi_bits(input int m, input logic [7:0] tx, input int n,
                          output logic [7:0] rx);
    logic cpol;
    logic cpha;
    cpol = m[1];
    cpha = m[0];
    rx   = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        r_mosi = tx[i];
        wait_clk(HALF);
        rx[i] = w_miso[m];
        r_mclk[m] = ~cpol;
        wait_clk(HALF);
        r_mclk[m] = cpol;
      end else begin
        r_mclk[m] = ~cpol;
        r_mosi = tx[i];
        wait_clk(HALF);
        rx[i] = w_miso[m];
        r_mclk[m] = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic spi_byte(input int m, input logic [7:0] tx, input logic [7:0] exp,
                          input string tag);
    logic [7:0] rx;
    spi_bits(m, tx, 8, rx);
    chk(tag, rx, exp);
  endtask

  task automatic run_echo(input int m);
    spi_select(m);
    spi_byte(m, 8'h11, 8'h00, $sformatf("echo%0d_r0", m));
    if (m == 3) chk("echo_st_start", 8'(g_dut[3].u_dut.r_state), 8'(S_START));
    spi_byte(m, 8'h42, 8'h22, $sformatf("echo%0d_r1", m));
    if (m == 3) chk("echo_st_echo", 8'(g_dut[3].u_dut.r_state), 8'(S_ECHO));
    spi_byte(m, 8'h43, 8'h42, $sformatf("echo%0d_r2", m));
    spi_byte(m, 8'h44, 8'h43, $sformatf("echo%0d_r3", m));
    spi_deselect(m);
    if (m == 3) chk("echo_st_idle", 8'(g_dut[3].u_dut.r_state), 8'(S_IDLE));
  endtask

  initial begin
    logic [7:0] rx;
    r_rst_n  = 1'b0;
    r_msel   = 4'hF;
    r_mclk   = 4'b1100;
    r_mosi   = 1'b0;
    r_pin    = 1'b0;
    r_pin_en = 1'b0;
    wait_clk(5);
    r_rst_n = 1'b1;
    wait_clk(5);

    chk("rst_miso", {7'd0, w_miso[3]}, 8'h00);
    chk("rst_err", {7'd0, w_err[3]}, 8'h00);
    chk("rst_state", 8'(g_dut[3].u_dut.r_state), 8'(S_IDLE));

    for (int m = 0; m < 4; m++) run_echo(m);

    // Known values at 3 and 6
    spi_select(3);
    spi_byte(3, 8'h12, 8'h00, "pre6_r0");
    spi_byte(3, 8'h06, 8'h23, "pre6_r1");
    spi_byte(3, 8'h66, 8'h00, "pre6_r2");
    spi_deselect(3);
    spi_select(3);
    spi_byte(3, 8'h12, 8'h00, "pre3_r0");
    spi_byte(3, 8'h03, 8'h23, "pre3_r1");
    spi_byte(3, 8'h33, 8'h00, "pre3_r2");
    spi_deselect(3);

    // Write 4..5, abort a partial byte aimed at 6
    spi_select(3);
    spi_byte(3, 8'h12, 8'h00, "wr_r0");
    spi_byte(3, 8'h04, 8'h23, "wr_r1");
    spi_byte(3, 8'hAB, 8'h00, "wr_r2");
    spi_byte(3, 8'hCD, 8'h00, "wr_r3");
    spi_bits(3, 8'hEF, 4, rx);
    spi_deselect(3);

    spi_select(3);
    spi_byte(3, 8'h13, 8'h00, "rd_r0");
    spi_byte(3, 8'h03, 8'h24, "rd_r1");
    spi_byte(3, 8'h00, 8'h33, "rd_ram3");
    spi_byte(3, 8'h00, 8'hAB, "rd_ram4");
    spi_byte(3, 8'h00, 8'hCD, "rd_ram5");
    spi_byte(3, 8'h00, 8'h66, "rd_ram6");
    spi_deselect(3);

    // Address wrap 15 -> 0
    spi_select(3);
    spi_byte(3, 8'h12, 8'h00, "wrap_w0");
    spi_byte(3, 8'h0F, 8'h23, "wrap_w1");
    spi_byte(3, 8'h11, 8'h00, "wrap_w2");
    spi_byte(3, 8'h22, 8'h00, "wrap_w3");
    spi_deselect(3);
    spi_select(3);
    spi_byte(3, 8'h13, 8'h00, "wrap_r0");
    spi_byte(3, 8'h0F, 8'h24, "wrap_r1");
    spi_byte(3, 8'h00, 8'h11, "wrap_ram15");
    spi_byte(3, 8'h00, 8'h22, "wrap_ram0");
    spi_deselect(3);

    // GPIO readback with pin 0 driven by the bench
    r_pin_en = 1'b1;
    r_pin    = 1'b0;
    spi_select(3);
    spi_byte(3, 8'h15, 8'h00, "gd_r0");
    spi_byte(3, 8'h00, 8'h26, "gd_r1");
    r_pin = 1'b1;
    spi_bits(3, 8'h00, 8, rx);
    chk("gd_pin_lo", {7'd0, rx[0]}, 8'h00);
    spi_bits(3, 8'h00, 8, rx);
    chk("gd_pin_hi", {7'd0, rx[0]}, 8'h01);
    spi_deselect(3);
    r_pin_en = 1'b0;

    spi_select(3);
    spi_byte(3, 8'h14, 8'h00, "dir_r0");
    spi_byte(3, 8'h01, 8'h25, "dir_r1");
    spi_deselect(3);
    wait_clk(2);
    chk("gpio0_out0", {7'd0, g_dut[3].w_gpio[0]}, 8'h00);
    spi_select(3);
    spi_byte(3, 8'h15, 8'h00, "out_r0");
    spi_byte(3, 8'h01, 8'h26, "out_r1");
    spi_deselect(3);
    wait_clk(2);
    chk("gpio0_out1", {7'd0, g_dut[3].w_gpio[0]}, 8'h01);

    // Invalid opcode, then INFO
    spi_select(3);
    spi_byte(3, 8'h99, 8'h00, "bad_r0");
    chk("bad_err1", {7'd0, w_err[3]}, 8'h01);
    chk("bad_state", 8'(g_dut[3].u_dut.r_state), 8'(S_ERR));
    spi_byte(3, 8'h00, 8'hEE, "bad_r1");
    spi_byte(3, 8'h00, 8'hEE, "bad_r2");
    spi_deselect(3);
    chk("bad_err0", {7'd0, w_err[3]}, 8'h00);
    spi_select(3);
    spi_byte(3, 8'h16, 8'h00, "info_r0");
    spi_byte(3, 8'h00, 8'h27, "info_r1");
    spi_byte(3, 8'h00, 8'h04, "info_gpio_w");
    spi_byte(3, 8'h00, 8'h04, "info_ram_aw");
    spi_byte(3, 8'h00, 8'h00, "info_r4");
    spi_deselect(3);
    chk("end_miso", {7'd0, w_miso[3]}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
